pixel_window_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator for 8-bit grayscale pixels in raster order. It buffers the two previous image lines and emits one full 3x3 window per interior pixel. Output windows are registered. The block sits between the grayscale conversion and the smoothing/filter stage of the image-processing top, which consumes the window directly.

---
 rtl/pixel_window_3x3_if.sv | 22 ++
 rtl/pixel_window_3x3.sv | 107 ++++++++++
 tb/tb_pixel_window_3x3.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_window_3x3_if.sv
// Pixel stream in / 3x3 window out bundle for pixel_window_3x3.
// The master drives the pixel stream; the slave (the window generator) drives the window side.
interface pixel_window_3x3_if;
   logic        in_valid;
   logic        in_sof;
   logic [7:0]  in_pixel;
   logic        win_valid;
   logic [71:0] win;
   logic [7:0]  out_row;
   logic [7:0]  out_col;
   logic        frame_done;

   modport master (
      output in_valid, in_sof, in_pixel,
      input  win_valid, win, out_row, out_col, frame_done
   );

   modport slave (
      input  in_valid, in_sof, in_pixel,
      output win_valid, win, out_row, out_col, frame_done
   );
endinterface

// File: rtl/pixel_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3-column shift window,
// emitting one registered window per interior pixel of a raster-order grayscale frame.
module pixel_window_3x3 #(
   parameter int unsigned IMG_WIDTH  = 8,
   parameter int unsigned IMG_HEIGHT = 8
) (
   input logic               clk,
   input logic               rst_n,
   pixel_window_3x3_if.slave bus
);
   localparam int unsigned AW       = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [7:0]  LAST_COL = 8'(IMG_WIDTH - 1);
   localparam logic [7:0]  LAST_ROW = 8'(IMG_HEIGHT - 1);

   logic [7:0]       col_q, col_d, row_q, row_d;
   logic [8:0][7:0]  sh_q, sh_d;
   logic [71:0]      win_q, win_d;
   logic [7:0]       out_row_q, out_row_d, out_col_q, out_col_d;
   logic             win_valid_q, win_valid_d;
   logic             frame_done_q, frame_done_d;
   logic [7:0]       r, c;
   logic [AW-1:0]    c_idx;
   logic             emit;

   logic [7:0] lb0_q [IMG_WIDTH];
   logic [7:0] lb1_q [IMG_WIDTH];

   always_comb begin
      // in_sof forces the accepted pixel to (0,0) whatever the counters say
      r     = bus.in_sof ? '0 : row_q;
      c     = bus.in_sof ? '0 : col_q;
      c_idx = c[AW-1:0];

      col_d        = col_q;
      row_d        = row_q;
      sh_d         = sh_q;
      win_d        = win_q;
      out_row_d    = out_row_q;
      out_col_d    = out_col_q;
      emit         = 1'b0;
      frame_done_d = 1'b0;

      if (bus.in_valid) begin
         if (c == LAST_COL) begin
            col_d = '0;
            row_d = (r == LAST_ROW) ? '0 : r + 8'd1;
         end else begin
            col_d = c + 8'd1;
            row_d = r;
         end

         for (int unsigned i = 0; i < 3; i++) begin
            sh_d[3*i]     = sh_q[3*i + 1];
            sh_d[3*i + 1] = sh_q[3*i + 2];
         end
         sh_d[2] = lb1_q[c_idx];
         sh_d[5] = lb0_q[c_idx];
         sh_d[8] = bus.in_pixel;

         emit         = (r >= 8'd2) && (c >= 8'd2);
         frame_done_d = (r == LAST_ROW) && (c == LAST_COL);

         if (emit) begin
            win_d     = sh_d;
            out_row_d = r - 8'd1;
            out_col_d = c - 8'd1;
         end
      end
      win_valid_d = emit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         sh_q         <= '0;
         win_q        <= '0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         sh_q         <= sh_d;
         win_q        <= win_d;
         out_row_q    <= out_row_d;
         out_col_q    <= out_col_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffers hold pixel data only; no window is emitted before they are refilled.
   always_ff @(posedge clk) begin
      if (bus.in_valid) begin
         lb1_q[c_idx] <= lb0_q[c_idx];
         lb0_q[c_idx] <= bus.in_pixel;
      end
   end

   assign bus.win        = win_q;
   assign bus.win_valid  = win_valid_q;
   assign bus.out_row    = out_row_q;
   assign bus.out_col    = out_col_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pixel_window_3x3.sv
// Directed bench for pixel_window_3x3: a 4x4 instance for frame behaviour and a 256x3 instance for maximum width.
module tb_pixel_window_3x3;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pixel_window_3x3_if bus ();
   pixel_window_3x3_if bus2 ();

   pixel_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );
   pixel_window_3x3 #(.IMG_WIDTH(256), .IMG_HEIGHT(3)) dut_max (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
   );

   int          n_vec = 0;
   int          n_miss = 0;
   int          acc_cnt = 0;
   int          frame_start_acc;
   int          first_win_acc;
   int          n_win;
   int          fd_at[$];
   logic [71:0] last_win;
   logic [71:0] win_first;
   logic [71:0] win_last;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_miss++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // Window of a frame whose pixel at (r,c) is base+16*r+c, centred on (rr,cc).
   function automatic logic [71:0] exp_win(input logic [7:0] base, input int rr, input int cc);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[8*(3*i+j) +: 8] = base + 8'(16*(rr-1+i) + (cc-1+j));
      return w;
   endfunction

   task automatic step(input logic v, input logic sof, input logic [7:0] pix);
      bus.in_valid = v;
      bus.in_sof   = sof;
      bus.in_pixel = pix;
      @(posedge clk);
      #1;
      if (v) acc_cnt++;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic step2(input logic v, input logic sof, input logic [7:0] pix);
      bus2.in_valid = v;
      bus2.in_sof   = sof;
      bus2.in_pixel = pix;
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
      bus2.in_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] base, input int gaps, input logic sof,
                             input int npix, input string tag);
      int r, c;
      logic [71:0] ew;
      n_win = 0;
      frame_start_acc = acc_cnt;
      for (int k = 0; k < npix; k++) begin
         r = k / 4;
         c = k % 4;
         step(1'b1, sof && (k == 0), base + 8'(16*r + c));
         chk({tag, " win_valid"}, 72'(bus.win_valid), 72'(r >= 2 && c >= 2));
         chk({tag, " frame_done"}, 72'(bus.frame_done), 72'(r == 3 && c == 3));
         if (bus.frame_done) fd_at.push_back(acc_cnt);
         if (r >= 2 && c >= 2) begin
            n_win++;
            ew = exp_win(base, r - 1, c - 1);
            chk({tag, " win"}, bus.win, ew);
            chk({tag, " out_row"}, 72'(bus.out_row), 72'(r - 1));
            chk({tag, " out_col"}, 72'(bus.out_col), 72'(c - 1));
            if (n_win == 1) begin
               win_first     = bus.win;
               first_win_acc = acc_cnt - frame_start_acc;
            end
            win_last = bus.win;
            last_win = ew;
         end
         for (int g = 0; g < gaps; g++) begin
            step(1'b0, 1'b0, 8'hEE);
            chk({tag, " gap win_valid"}, 72'(bus.win_valid), 72'(0));
            chk({tag, " gap frame_done"}, 72'(bus.frame_done), 72'(0));
            chk({tag, " gap win hold"}, bus.win, last_win);
         end
      end
      if (npix == 16) chk({tag, " window count"}, 72'(n_win), 72'(4));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " win_valid"}, 72'(bus.win_valid), 72'(0));
      chk({tag, " frame_done"}, 72'(bus.frame_done), 72'(0));
      chk({tag, " win"}, bus.win, 72'(0));
      chk({tag, " out_row"}, 72'(bus.out_row), 72'(0));
      chk({tag, " out_col"}, 72'(bus.out_col), 72'(0));
   endtask

   initial begin
      int          n_win2;
      logic [71:0] ew2;

      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_pixel  = '0;
      bus2.in_valid = 1'b0;
      bus2.in_sof   = 1'b0;
      bus2.in_pixel = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst_n    = 1'b1;
      last_win = '0;

      // Basic 4x4 frame, hand-computed landmarks
      send_frame(8'h00, 0, 1'b1, 16, "basic");
      chk("basic first index", 72'(first_win_acc), 72'(11));
      chk("basic first byte0", 72'(win_first[7:0]), 72'(8'h00));
      chk("basic first byte4", 72'(win_first[39:32]), 72'(8'h11));
      chk("basic first byte8", 72'(win_first[71:64]), 72'(8'h22));
      chk("basic last byte8", 72'(win_last[71:64]), 72'(8'h33));

      // Same frame with three idle cycles after every pixel
      send_frame(8'h00, 3, 1'b1, 16, "gaps");

      // Back-to-back frames, second relies on the counter wrap
      fd_at.delete();
      send_frame(8'h00, 0, 1'b1, 16, "b2b1");
      send_frame(8'h80, 0, 1'b0, 16, "b2b2");
      chk("b2b2 first byte0", 72'(win_first[7:0]), 72'(8'h80));
      chk("b2b2 first byte8", 72'(win_first[71:64]), 72'(8'hA2));
      chk("b2b frame_done count", 72'(fd_at.size()), 72'(2));
      if (fd_at.size() == 2) chk("b2b frame_done spacing", 72'(fd_at[1] - fd_at[0]), 72'(16));

      // Aborted frame then SOF resync
      fd_at.delete();
      send_frame(8'h40, 0, 1'b1, 6, "abort");
      send_frame(8'h00, 0, 1'b1, 16, "resync");
      chk("resync frame_done count", 72'(fd_at.size()), 72'(1));

      // Reset after nine pixels, then a frame without SOF
      send_frame(8'h20, 0, 1'b1, 9, "pre_reset");
      rst_n = 1'b0;
      step(1'b0, 1'b0, 8'h00);
      chk_reset_state("mid reset");
      rst_n    = 1'b1;
      last_win = '0;
      send_frame(8'h10, 0, 1'b0, 16, "post_reset");
      chk("post_reset first byte0", 72'(win_first[7:0]), 72'(8'h10));

      // 256x3 frame, pixel value = column
      n_win2 = 0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 256; c++) begin
            step2(1'b1, (r == 0) && (c == 0), 8'(c));
            if (r == 2 && c >= 2) begin
               n_win2++;
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     ew2[8*(3*i+j) +: 8] = 8'(c - 2 + j);
               chk("max win_valid", 72'(bus2.win_valid), 72'(1));
               chk("max win", bus2.win, ew2);
               chk("max out_row", 72'(bus2.out_row), 72'(1));
               chk("max out_col", 72'(bus2.out_col), 72'(c - 1));
               chk("max frame_done", 72'(bus2.frame_done), 72'(c == 255));
            end else begin
               chk("max no window", 72'({bus2.win_valid, bus2.frame_done}), 72'(0));
            end
         end
      end
      chk("max window count", 72'(n_win2), 72'(254));
      chk("max last byte8", 72'(bus2.win[71:64]), 72'(8'hFF));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
